// File: rtl/ct_pkg.sv
// Shared definitions for the CT butterfly scheduler: FSM states and the
// radix-2 DIT butterfly address mapping (also usable by CT_BU models).
package ct_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ct_state_e;

  // Widest supported transform is 2^12 points.
  localparam int CT_AW = 12;

  typedef struct packed {
    logic [CT_AW-1:0] p;
    logic [CT_AW-1:0] q;
    logic [CT_AW-1:0] tw;
  } ct_addr_t;

  // Butterfly j of stage s pairs elements 'half' apart inside blocks of 2*half.
  function automatic ct_addr_t ct_bfly_addr(input logic [CT_AW-1:0] j,
                                            input logic [3:0]       s,
                                            input logic [3:0]       log_n);
    logic [CT_AW-1:0] half;
    logic [CT_AW-1:0] low;
    ct_addr_t         r;
    half = CT_AW'(1) << s;
    low  = j & (half - CT_AW'(1));
    r.p  = ((j >> s) << (s + 4'd1)) | low;
    r.q  = r.p + half;
    r.tw = low << (log_n - 4'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/ct_addr_gen.sv
// Combinational butterfly address generator: (j, s) -> (p, q, tw),
// narrowed from the package's full-width mapping to this transform size.
module ct_addr_gen
  import ct_pkg::*;
#(
  parameter int LOG_N = 4
) (
  input  logic [LOG_N-2:0] j,
  input  logic [LOG_N-1:0] s,
  output logic [LOG_N-1:0] p,
  output logic [LOG_N-1:0] q,
  output logic [LOG_N-2:0] tw
);

  // Only the low bits are meaningful; everything above LOG_N is zero.
  ct_addr_t wide_unused;

  always_comb begin
    wide_unused = ct_bfly_addr(CT_AW'(j), 4'(s), 4'(LOG_N));
  end

  assign p  = wide_unused.p[LOG_N-1:0];
  assign q  = wide_unused.q[LOG_N-1:0];
  assign tw = wide_unused.tw[LOG_N-2:0];

endmodule

// File: rtl/ct_bu_sched.sv
// Sequencer for one radix-2 CT butterfly unit: issues one butterfly per cycle,
// flushes between stages and replays the addresses as write-backs L cycles later.
module ct_bu_sched
  import ct_pkg::*;
#(
  parameter int LOG_N  = 4,
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG_N-1:0] stage_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_p_o,
  output logic [LOG_N-1:0] rd_addr_q_o,
  output logic [LOG_N-2:0] tw_addr_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_p_o,
  output logic [LOG_N-1:0] wr_addr_q_o
);

  localparam int L      = RD_LAT + BU_LAT;
  localparam int NH     = 1 << (LOG_N - 1);
  localparam int FCW    = (L > 1) ? $clog2(L) : 1;

  typedef struct packed {
    logic             v;
    logic [LOG_N-1:0] p;
    logic [LOG_N-1:0] q;
  } wb_t;

  ct_state_e        state;
  logic [LOG_N-2:0] j;
  logic [FCW-1:0]   fc;
  wb_t              line [L];

  logic [LOG_N-1:0] p_n;
  logic [LOG_N-1:0] q_n;
  logic [LOG_N-2:0] tw_n;

  ct_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
    .j  (j),
    .s  (stage_o),
    .p  (p_n),
    .q  (q_n),
    .tw (tw_n)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      j           <= '0;
      fc          <= '0;
      stage_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_p_o <= '0;
      rd_addr_q_o <= '0;
      tw_addr_o   <= '0;
    end else begin
      rd_en_o     <= 1'b0;
      rd_addr_p_o <= '0;
      rd_addr_q_o <= '0;
      tw_addr_o   <= '0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= RUN;
            j       <= '0;
            stage_o <= '0;
          end
        end
        RUN: begin
          busy_o <= 1'b1;
          if (!hold_i) begin
            rd_en_o     <= 1'b1;
            rd_addr_p_o <= p_n;
            rd_addr_q_o <= q_n;
            tw_addr_o   <= tw_n;
            if (j == (LOG_N-1)'(NH - 1)) begin
              j     <= '0;
              fc    <= '0;
              state <= FLUSH;
            end else begin
              j <= j + (LOG_N-1)'(1);
            end
          end
        end
        // Wait out the issue-to-write latency so stage s+1 never reads stale data.
        FLUSH: begin
          busy_o <= 1'b1;
          if (fc == FCW'(L - 1)) begin
            if (stage_o == LOG_N'(LOG_N - 1)) begin
              state <= DONE;
            end else begin
              stage_o <= stage_o + LOG_N'(1);
              state   <= RUN;
            end
          end else begin
            fc <= fc + FCW'(1);
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          stage_o <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line: entry L-1 is the read issue of exactly L cycles ago.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < L; i++) line[i] <= '0;
    end else begin
      line[0] <= {rd_en_o, rd_addr_p_o, rd_addr_q_o};
      for (int i = 1; i < L; i++) line[i] <= line[i-1];
    end
  end

  assign wr_en_o     = line[L-1].v;
  assign wr_addr_p_o = line[L-1].p;
  assign wr_addr_q_o = line[L-1].q;

endmodule
